cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates the single physical-register-file write port (the common data bus, CDB) among NUM_REQ completing functional units in the out-of-order pipeline. Each requester hands off one completed result (physical tag, value, register-write flag) through a valid/ready handshake into a private one-entry buffer. A round-robin arbiter selects one buffered result per cycle and drives it, registered, onto the CDB outputs. The CDB outputs feed phy_reg_file's p_rd / wr_data_in / RegDest_compl write inputs and the wakeup/ROB completion logic.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8)
- DATA_W, 32, result width
- TAG_W, 6, physical register tag width (64 physical registers)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  mispredict/exception squash; synchronous
- req_valid  in  NUM_REQ  requester i has a result this cycle
- req_tag  in  NUM_REQ*TAG_W  destination tag, requester i in bits [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  result value, packed the same way
- req_regdest  in  NUM_REQ  1 = result writes a register
- req_ready  out  NUM_REQ  buffer i can accept this cycle
- cdb_valid  out  1  CDB carries a result this cycle
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast value
- cdb_regdest  out  1  register-file write enable for this result (0 when cdb_valid=0)

## Operation
- Per requester: buffer {buf_valid, buf_tag, buf_data, buf_regdest}.
- Accept: requester i is accepted at a rising edge when req_valid[i] & req_ready[i] in that cycle. Its fields are loaded into buffer i and buf_valid[i] is set.
- req_ready[i] = ~flush & (~buf_valid[i] | grant[i]). This allows back-to-back hand-off at 1 result per cycle per requester while that requester wins.
- grant is a function of buf_valid and rr_ptr only, never of req_valid, so there is no combinational loop.
- Arbitration: search buf_valid starting at index rr_ptr, ascending, wrapping at NUM_REQ-1 to 0. The first set entry wins; at most one grant per cycle.
- On a grant to i:
  - Next edge: cdb_* load buffer i's fields; cdb_valid=1; cdb_regdest=buf_regdest[i].
  - buf_valid[i] clears, unless a new accept for i occurs in the same cycle, in which case the buffer reloads.
  - rr_ptr becomes (i+1) mod NUM_REQ.
- No grant: next edge cdb_valid=0 and cdb_regdest=0. cdb_tag and cdb_data hold their last value. rr_ptr is unchanged.
- A result with regdest=0 is still broadcast (for ROB completion) with cdb_regdest=0.
- Flush:
  - All buf_valid clear and cdb_valid/cdb_regdest go to 0 at the next edge.
  - No accepts and no grants take effect in the flush cycle; req_ready is 0 for that cycle.
  - rr_ptr is unchanged.
- Fairness: a buffered entry is granted within NUM_REQ cycles of becoming valid.

## Timing
- Reset (rst=1 at an edge):
  - buf_valid all 0; rr_ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_regdest=0.
  - req_ready reads all-ones in the cycle after reset, provided flush=0.
- Reset mid-operation discards all buffered and in-flight results. rst has priority over flush, which has priority over accept/grant.
- Latency: accepted at edge N, the buffer is valid in cycle N+1. If granted in that cycle, cdb_valid=1 in cycle N+2. Minimum latency is 2 cycles; each cycle of lost arbitration adds 1.
- Throughput: 1 CDB result per cycle whenever any buffer is valid.
- Buffer full and not granted: req_ready[i]=0; the requester must hold req_valid and its fields stable.
- cdb_* are registered outputs with no combinational path from req_* inputs.

## Test plan
- Reset, then a single requester: rst high 2 cycles, then req 2 presents tag=6'h15, data=32'hDEADBEEF, regdest=1 for one cycle -> cdb_valid=1 exactly 2 cycles after the accept edge with tag 6'h15, data DEADBEEF, cdb_regdest=1; every other cycle cdb_valid=0; rr_ptr=3.
- All four requesters valid continuously from reset -> CDB grant order 0,1,2,3,0,1,...; cdb_valid=1 every cycle; each req_ready asserts only in its grant cycle once the buffers are full.
- Requester 1 streams 8 back-to-back results while others are idle -> all 8 appear on consecutive cycles in order; req_ready[1] stays 1.
- regdest=0 result from req 3 (tag 6'h2A) -> cdb_valid=1, cdb_tag=6'h2A, cdb_regdest=0.
- Flush with buffers 0 and 2 full and req 1 valid in the flush cycle -> req_ready=0 during flush; cdb_valid=0 next cycle; none of the three results ever appears on the CDB; rr_ptr unchanged.
- rst asserted while 3 buffers are full and cdb_valid=1 -> next cycle all cdb_* = 0 and req_ready=4'b1111; no stale result appears on the CDB afterward.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of buffered FU results onto the registered CDB write port.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_regdest,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      cdb_regdest
);
    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0]   buf_tag_q [NUM_REQ];
    logic [TAG_W-1:0]   buf_tag_d [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
    logic [DATA_W-1:0]  buf_data_d [NUM_REQ];
    logic [NUM_REQ-1:0] buf_regdest_q, buf_regdest_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic               cdb_regdest_q, cdb_regdest_d;
    logic [NUM_REQ-1:0] grant, accept;
    logic [PW-1:0]      gidx, idx;
    logic [PW:0]        pos;

    // Grant depends only on buffer state and pointer, keeping req_ready free of req_valid.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr_q} + (PW+1)'(k);
            pos = (pos >= (PW+1)'(NUM_REQ)) ? pos - (PW+1)'(NUM_REQ) : pos;
            idx = pos[PW-1:0];
            if (grant == '0 && buf_valid_q[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    assign req_ready = {NUM_REQ{~flush}} & (~buf_valid_q | grant);
    assign accept    = req_valid & req_ready;

    always_comb begin
        buf_tag_d     = buf_tag_q;
        buf_data_d    = buf_data_q;
        buf_regdest_d = buf_regdest_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (accept[k]) begin
                buf_tag_d[k]     = req_tag[k*TAG_W +: TAG_W];
                buf_data_d[k]    = req_data[k*DATA_W +: DATA_W];
                buf_regdest_d[k] = req_regdest[k];
            end
        end
        buf_valid_d   = flush ? '0 : accept | (buf_valid_q & ~grant);
        cdb_valid_d   = ~flush & (|grant);
        cdb_regdest_d = cdb_valid_d & buf_regdest_q[gidx];
        cdb_tag_d     = cdb_valid_d ? buf_tag_q[gidx] : cdb_tag_q;
        cdb_data_d    = cdb_valid_d ? buf_data_q[gidx] : cdb_data_q;
        rr_ptr_d      = !cdb_valid_d ? rr_ptr_q : (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk) begin
        buf_tag_q     <= buf_tag_d;
        buf_data_q    <= buf_data_d;
        buf_regdest_q <= buf_regdest_d;
        if (rst) begin
            buf_valid_q   <= '0;
            rr_ptr_q      <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_tag_q     <= '0;
            cdb_data_q    <= '0;
            cdb_regdest_q <= 1'b0;
        end else begin
            buf_valid_q   <= buf_valid_d;
            rr_ptr_q      <= rr_ptr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_tag_q     <= cdb_tag_d;
            cdb_data_q    <= cdb_data_d;
            cdb_regdest_q <= cdb_regdest_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_data    = cdb_data_q;
    assign cdb_regdest = cdb_regdest_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [23:0] req_tag = '0;
    logic [127:0] req_data = '0;
    logic [3:0]  req_regdest = '0;
    logic [3:0]  req_ready;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_regdest;
    int checks = 0;
    int failures = 0;

    cdb_arbiter #(.NUM_REQ(4), .DATA_W(32), .TAG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_regdest(req_regdest), .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_regdest(cdb_regdest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] t, input logic [31:0] d, input logic rd);
        req_tag[i*6 +: 6]    = t;
        req_data[i*32 +: 32] = d;
        req_regdest[i]       = rd;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid", 64'(cdb_valid), 64'h0);
        check("rst_tag", 64'(cdb_tag), 64'h0);
        check("rst_data", 64'(cdb_data), 64'h0);
        check("rst_regdest", 64'(cdb_regdest), 64'h0);
        check("rst_ready", 64'(req_ready), 64'hf);

        // single requester 2
        set_req(2, 6'h15, 32'hDEADBEEF, 1'b1);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("single_n1_valid", 64'(cdb_valid), 64'h0);
        tick();
        check("single_valid", 64'(cdb_valid), 64'h1);
        check("single_tag", 64'(cdb_tag), 64'h15);
        check("single_data", 64'(cdb_data), 64'hDEADBEEF);
        check("single_regdest", 64'(cdb_regdest), 64'h1);
        tick();
        check("single_after_valid", 64'(cdb_valid), 64'h0);
        check("single_hold_tag", 64'(cdb_tag), 64'h15);
        check("single_after_regdest", 64'(cdb_regdest), 64'h0);

        // rr_ptr is 3: requester 3 beats requester 0
        set_req(0, 6'h01, 32'h1, 1'b1);
        set_req(3, 6'h03, 32'h3, 1'b1);
        req_valid = 4'b1001;
        tick();
        req_valid = '0;
        tick();
        check("rr3_first", 64'(cdb_tag), 64'h03);
        tick();
        check("rr3_second", 64'(cdb_tag), 64'h01);
        check("rr3_second_valid", 64'(cdb_valid), 64'h1);
        tick();
        check("rr3_idle", 64'(cdb_valid), 64'h0);

        // regdest=0 result still broadcast
        set_req(3, 6'h2A, 32'h12345678, 1'b0);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        check("nord_valid", 64'(cdb_valid), 64'h1);
        check("nord_tag", 64'(cdb_tag), 64'h2A);
        check("nord_data", 64'(cdb_data), 64'h12345678);
        check("nord_regdest", 64'(cdb_regdest), 64'h0);
        tick();

        // requester 1 streams 8 back-to-back
        for (int k = 0; k < 8; k++) begin
            set_req(1, 6'(32'h20 + k), 32'(k * 3 + 7), 1'b1);
            req_valid = 4'b0010;
            #1;
            check("stream_ready", 64'(req_ready[1]), 64'h1);
            tick();
            if (k > 0) begin
                check("stream_valid", 64'(cdb_valid), 64'h1);
                check("stream_tag", 64'(cdb_tag), 64'(32'h20 + k - 1));
                check("stream_data", 64'(cdb_data), 64'((k - 1) * 3 + 7));
            end
        end
        req_valid = '0;
        tick();
        check("stream_last_tag", 64'(cdb_tag), 64'h27);
        check("stream_last_valid", 64'(cdb_valid), 64'h1);
        tick();
        check("stream_end", 64'(cdb_valid), 64'h0);

        // flush with buffers 0 and 2 full, requester 1 offering (rr_ptr is 2)
        set_req(0, 6'h30, 32'h50, 1'b1);
        set_req(2, 6'h32, 32'h52, 1'b1);
        req_valid = 4'b0101;
        tick();
        set_req(1, 6'h31, 32'h51, 1'b1);
        req_valid = 4'b0010;
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(req_ready), 64'h0);
        tick();
        flush = 1'b0;
        req_valid = '0;
        check("flush_valid", 64'(cdb_valid), 64'h0);
        check("flush_regdest", 64'(cdb_regdest), 64'h0);
        #1;
        check("flush_ready_after", 64'(req_ready), 64'hf);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_no_stale", 64'(cdb_valid), 64'h0);
        end

        // rr_ptr still 2 after flush: requester 2 beats requester 1
        set_req(1, 6'h11, 32'h11, 1'b1);
        set_req(2, 6'h12, 32'h12, 1'b1);
        req_valid = 4'b0110;
        tick();
        req_valid = '0;
        tick();
        check("flush_rr_first", 64'(cdb_tag), 64'h12);
        tick();
        check("flush_rr_second", 64'(cdb_tag), 64'h11);
        tick();

        // all four continuously valid from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 6'(32'h38 + i), 32'(32'hA0 + i), 1'b1);
        req_valid = 4'b1111;
        #1;
        check("all_ready_empty", 64'(req_ready), 64'hf);
        tick();
        for (int c = 0; c < 8; c++) begin
            #1;
            check("all_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            tick();
            check("all_valid", 64'(cdb_valid), 64'h1);
            check("all_tag", 64'(cdb_tag), 64'(32'h38 + c % 4));
        end

        // reset while three buffers are full and the CDB is busy
        req_valid = '0;
        tick();
        check("pre_rst_valid", 64'(cdb_valid), 64'h1);
        check("pre_rst_tag", 64'(cdb_tag), 64'h38);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(cdb_valid), 64'h0);
        check("mid_rst_tag", 64'(cdb_tag), 64'h0);
        check("mid_rst_data", 64'(cdb_data), 64'h0);
        check("mid_rst_regdest", 64'(cdb_regdest), 64'h0);
        check("mid_rst_ready", 64'(req_ready), 64'hf);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_idle", 64'(cdb_valid), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
